flash_read_arbiter: RTL
=======================

Name: flash_read_arbiter

Overview:
- Shares the single SPI flash read engine among NUM_REQ requesters (sound channels, sample prefetch, boot loader).
- Round-robin grants one request at a time and drives the engine's load/addr handshake.
- Waits for the 40-bit read-command transaction to complete and returns the byte to the granted requester with a one-cycle ack.
- Sits between the requesters and the SPI flash read controller.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 1023: clock cycles allowed in WAIT_BUSY+WAIT_DONE before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  NUM_REQ  per-requester read request; level, held until ack
- req_addr  in  24*NUM_REQ  byte address; requester i uses bits [24*i+23:24*i]
- ack  out  NUM_REQ  one-cycle pulse; rd_data is valid for ack[i]
- rd_data  out  8  returned byte; holds its value until the next ack
- err  out  1  one-cycle pulse coincident with an aborted ack
- busy  out  1  high in every state except IDLE
- flash_load  out  1  load strobe to the flash engine
- flash_addr  out  24  address to the flash engine
- flash_ready  in  1  engine idle flag; registered, lags load by one cycle
- flash_data  in  8  engine read byte; valid when flash_ready rises

Behaviour:
- Reset values: ack=0, rd_data=8'h00, err=0, busy=0, flash_load=0, flash_addr=0, state=IDLE, rr pointer=0.
- Reset mid-transaction: return to IDLE immediately and issue no ack. The engine is reset separately.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch the grant index g and req_addr[g] into flash_addr, then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - flash_load=1.
  - If flash_ready=1, go to WAIT_BUSY. Otherwise stay in ISSUE with load held; the engine is still finishing a prior transfer.
- WAIT_BUSY:
  - flash_load=0. It must be low here: the engine still shows ready for one cycle and would reload on a held load.
  - When flash_ready=0, go to WAIT_DONE.
- WAIT_DONE:
  - When flash_ready=1: rd_data<=flash_data, ack[g]<=1 for exactly one cycle, rr pointer<=(g+1) mod NUM_REQ, go to IDLE.
- flash_addr stays stable from grant until ack.
- ack goes high the cycle after flash_ready is sampled high in WAIT_DONE.
- Minimum grant-to-ack latency is engine transfer time + 3 cycles.
- req is sampled only in IDLE. If a requester deasserts req after grant, the transaction still completes and its ack still pulses.
- In the ack cycle the FSM is in IDLE and may grant again on the next edge. Requesters must drop req in the ack cycle or they get a second read.
- Only one ack bit is ever high at a time. ack and err are never high in IDLE without a completed or aborted transaction.
- Address bits pass through unchanged; no increment or wrap logic.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- With the macro:
  - A 10-bit counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT: ack[g]=1, err=1, rd_data=8'hFF, rr pointer advances, go to IDLE.
- Without the macro: no counter exists, err is tied to 0, and the FSM waits indefinitely.

Test Plan:
- Single read: req[1]=1, addr 24'h012345, engine model returns 8'hA5 → exactly one flash_load pulse with flash_addr=24'h012345, one ack[1] pulse, rd_data=8'hA5, busy back to 0.
- Round-robin: req=4'b1111 held, each dropped on its own ack → grant order 0,1,2,3. Re-raise req[0], req[2] → order 0,2.
- Load handshake: engine model keeps flash_ready=0 for 5 cycles at ISSUE → flash_load held 5+1 cycles. flash_load is never high in WAIT_BUSY. Engine sees exactly one load.
- Late drop: req[3] deasserted 2 cycles after grant → transaction completes and ack[3] still pulses once with the correct data.
- Reset in WAIT_DONE: rst=1 for 1 cycle → no ack, busy=0, flash_load=0. A subsequent req[2] is granted first because rr pointer=0 and only req[2] is set.
- With FLASH_ARB_TIMEOUT_EN and TIMEOUT=20: engine never raises flash_ready → ack[g] and err pulse on the 20th wait cycle with rd_data=8'hFF. Without the macro: no ack and err stays 0.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash read engine among NUM_REQ requesters.
// Define FLASH_ARB_TIMEOUT_EN to abort stalled transfers after TIMEOUT wait cycles (err pulses with the ack).
module flash_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      ack,
  output logic [7:0]              rd_data,
  output logic                    err,
  output logic                    busy,
  output logic                    flash_load,
  output logic [23:0]             flash_addr,
  input  logic                    flash_ready,
  input  logic [7:0]              flash_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_param
    $error("flash_read_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [23:0]          addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     pick;
  logic [23:0]          addr_arr [NUM_REQ];

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  logic [9:0]           tmo_q, tmo_d;
  logic                 err_q, err_d;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[24*gi +: 24];
  end

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = '0;
    pick    = rr_pick(req, rr_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          addr_d  = addr_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flash_ready) state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Ready still reads high for one cycle after the load is taken.
        if (!flash_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (flash_ready) begin
          data_d         = flash_data;
          ack_d[grant_q] = 1'b1;
          rr_d           = next_idx(grant_q);
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FLASH_ARB_TIMEOUT_EN
    err_d = 1'b0;
    tmo_d = tmo_q;
    if (state_q == ISSUE) begin
      tmo_d = '0;
    end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      tmo_d = tmo_q + 10'd1;
      // A real completion in the same cycle wins over the abort.
      if (state_d != IDLE && tmo_q == TMO_LAST) begin
        data_d         = 8'hFF;
        ack_d[grant_q] = 1'b1;
        err_d          = 1'b1;
        rr_d           = next_idx(grant_q);
        state_d        = IDLE;
      end
    end
`endif

    load_d = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      ack_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
`ifdef FLASH_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign rd_data    = data_q;
  assign busy       = busy_q;
  assign flash_load = load_q;
  assign flash_addr = addr_q;

`ifdef FLASH_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
